// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Program-counter and fetch-control stage. Drives the byte
//             address into the instruction memory's asynchronous read port
//             and selects the next PC (sequential, branch, jump or trap).
//             Provides boot sequencing, stall hold, halt, target fault
//             detection and a saturating fetch counter.
//  Ports    : clk             - rising-edge clock
//             rst_n           - asynchronous active-low reset
//             stall_i         - hold PC, ignore redirects
//             branch_taken_i  - take branch_target_i
//             branch_target_i - branch destination (byte address)
//             jump_i          - take jump_target_i (wins over branch)
//             jump_target_i   - jump destination (byte address)
//             halt_req_i      - stop fetching after this cycle
//             pc_o            - current fetch byte address (registered)
//             pc_plus4_o      - pc_o + 4, combinational
//             instr_valid_o   - instruction at pc_o executes this cycle
//             fetch_fault_o   - one-cycle pulse while in TRAP
//             fault_addr_o    - last faulting target
//             halted_o        - high in HALT
//             fetch_count_o   - saturating count of executed fetches
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned MEM_SIZE     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        halt_req_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    output logic        fetch_fault_o,
    output logic [31:0] fault_addr_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [31:0] C_MEM_WORDS = 32'(MEM_SIZE);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] count_q, count_d;

    logic [32:0] w_seq_sum;
    logic [31:0] w_cand;
    logic        w_cand_wrap;
    logic        w_cand_fault;
    logic        w_fetch_en;

    // Carry out of the 33-bit sum flags a sequential fetch past 0xFFFF_FFFC.
    assign w_seq_sum  = {1'b0, pc_q} + 33'd4;
    assign pc_plus4_o = w_seq_sum[31:0];

    // Redirect priority: jump over branch over sequential.
    always_comb begin
        w_cand      = w_seq_sum[31:0];
        w_cand_wrap = w_seq_sum[32];
        if (jump_i) begin
            w_cand      = jump_target_i;
            w_cand_wrap = 1'b0;
        end else if (branch_taken_i) begin
            w_cand      = branch_target_i;
            w_cand_wrap = 1'b0;
        end
    end

    assign w_cand_fault = (w_cand[1:0] != 2'b00)
                        || ({2'b00, w_cand[31:2]} >= C_MEM_WORDS)
                        || w_cand_wrap;

    // A fetch executes whenever RUN is not stalled, including the edge that
    // halts or faults.
    assign w_fetch_en = (state_q == ST_RUN) && !stall_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_addr_d = fault_addr_q;
        count_d      = count_q;

        if (w_fetch_en && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req_i) begin
                    state_d = ST_HALT;
                end else if (!stall_i) begin
                    if (w_cand_fault) begin
                        pc_d         = TRAP_VECTOR;
                        fault_addr_d = w_cand;
                        state_d      = ST_TRAP;
                    end else begin
                        pc_d = w_cand;
                    end
                end
            end
            ST_TRAP: begin
                // PC already holds the trap vector; handler runs next cycle.
                state_d = ST_RUN;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            fault_addr_q <= 32'h0;
            count_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_addr_q <= fault_addr_d;
            count_q      <= count_d;
        end
    end

    assign pc_o          = pc_q;
    assign fault_addr_o  = fault_addr_q;
    assign fetch_count_o = count_q;
    assign instr_valid_o = w_fetch_en;
    assign fetch_fault_o = (state_q == ST_TRAP);
    assign halted_o      = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Scoreboard bench for fetch_unit. A reference model predicts
//             each cycle's outputs; a monitor compares them on the falling
//             edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_RESET = 32'h0000_0000;
    localparam logic [31:0] C_TRAP  = 32'h0000_0100;
    localparam int          C_MEM   = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, br = 1'b0, jmp = 1'b0, halt = 1'b0;
    logic [31:0] bt = 32'h0, jt = 32'h0;
    logic [31:0] pc, pc_plus4, fault_addr, fetch_count;
    logic        instr_valid, fetch_fault, halted;

    fetch_unit #(
        .RESET_VECTOR (C_RESET),
        .TRAP_VECTOR  (C_TRAP),
        .MEM_SIZE     (C_MEM)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (bt),
        .jump_i          (jmp),
        .jump_target_i   (jt),
        .halt_req_i      (halt),
        .pc_o            (pc),
        .pc_plus4_o      (pc_plus4),
        .instr_valid_o   (instr_valid),
        .fetch_fault_o   (fetch_fault),
        .fault_addr_o    (fault_addr),
        .halted_o        (halted),
        .fetch_count_o   (fetch_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef enum int { M_BOOT, M_RUN, M_TRAP, M_HALT } mode_t;
    mode_t       m_mode;
    logic [31:0] m_pc, m_fault, m_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
        logic        halted;
        logic [31:0] faddr;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];

    function automatic void model_reset();
        m_mode  = M_BOOT;
        m_pc    = C_RESET;
        m_fault = 32'h0;
        m_count = 32'h0;
    endfunction

    function automatic void model_step(logic s, logic b, logic [31:0] btg,
                                       logic j, logic [31:0] jtg, logic h);
        longint cand;
        bit     bad;
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_TRAP: m_mode = M_RUN;
            M_HALT: ;
            M_RUN: begin
                if (!s && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
                if (h) begin
                    m_mode = M_HALT;
                end else if (!s) begin
                    if (j)      cand = longint'(jtg);
                    else if (b) cand = longint'(btg);
                    else        cand = longint'(m_pc) + 4;
                    bad = (cand % 4 != 0) || (cand / 4 >= C_MEM)
                       || (cand > 64'h0_FFFF_FFFF);
                    if (bad) begin
                        m_fault = cand[31:0];
                        m_pc    = C_TRAP;
                        m_mode  = M_TRAP;
                    end else begin
                        m_pc = cand[31:0];
                    end
                end
            end
            default: ;
        endcase
    endfunction

    // One clock cycle: apply inputs, predict this cycle's outputs, then advance.
    task automatic cycle(logic s, logic b, logic [31:0] btg,
                         logic j, logic [31:0] jtg, logic h);
        exp_t e;
        stall = s; br = b; bt = btg; jmp = j; jt = jtg; halt = h;
        e.pc     = m_pc;
        e.pc4    = m_pc + 32'd4;
        e.valid  = (m_mode == M_RUN) && !s;
        e.fault  = (m_mode == M_TRAP);
        e.halted = (m_mode == M_HALT);
        e.faddr  = m_fault;
        e.count  = m_count;
        sb.push_back(e);
        @(posedge clk);
        model_step(s, b, btg, j, jtg, h);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Drop reset in the second half of a cycle and check it acts at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        stall = 1'b0; br = 1'b0; jmp = 1'b0; halt = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pc",          pc,                   C_RESET);
        chk("rst_fetch_fault", {31'h0, fetch_fault}, 32'h0);
        chk("rst_count",       fetch_count,          32'h0);
        chk("rst_fault_addr",  fault_addr,           32'h0);
        chk("rst_valid",       {31'h0, instr_valid}, 32'h0);
        chk("rst_halted",      {31'h0, halted},      32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc",          pc,                   e.pc);
            chk("pc_plus4",    pc_plus4,             e.pc4);
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, e.valid});
            chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, e.fault});
            chk("halted",      {31'h0, halted},      {31'h0, e.halted});
            chk("fault_addr",  fault_addr,           e.faddr);
            chk("fetch_count", fetch_count,          e.count);
        end
    end

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        if ($urandom_range(0, 15) == 0) t = $urandom();
        else                            t = 32'($urandom_range(0, 300)) * 4;
        if ($urandom_range(0, 7) == 0)  t = t + 32'($urandom_range(1, 3));
        return t;
    endfunction

    logic [31:0] saved_count;

    initial begin
        model_reset();
        #12;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: boot then sequential fetch
        idle(4);
        chk("t1_pc",    pc,          32'd12);
        chk("t1_count", fetch_count, 32'd3);

        // 2: jump beats branch; stall blocks both
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        chk("t2_jump_wins", pc, 32'h80);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0);
        saved_count = fetch_count;
        cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        chk("t2_stall_pc",    pc,          32'h8);
        chk("t2_stall_count", fetch_count, saved_count);

        // 3: misaligned jump traps
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h22, 1'b0);
        chk("t3_trap_pc",    pc,                   32'h100);
        chk("t3_trap_flag",  {31'h0, fetch_fault}, 32'h1);
        chk("t3_fault_addr", fault_addr,           32'h22);
        idle(2);
        chk("t3_after_trap", pc, 32'h104);

        // 4: sequential run off the end of memory, then branch to 0x400
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h3F8, 1'b0);
        idle(2);
        chk("t4_seq_fault", fault_addr, 32'h400);
        chk("t4_seq_pc",    pc,         32'h100);
        idle(1);
        cycle(1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
        chk("t4_br_fault_flag", {31'h0, fetch_fault}, 32'h1);

        // 5: halt with stall, then random inputs have no effect
        idle(1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++)
            cycle(1'($urandom()), 1'($urandom()), rnd_target(),
                  1'($urandom()), rnd_target(), 1'($urandom()));
        chk("t5_halted_pc", pc, 32'h10);

        // 6: async reset while in TRAP
        do_reset();
        idle(2);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h22, 1'b0);
        chk("t6_in_trap", {31'h0, fetch_fault}, 32'h1);
        do_reset();
        idle(4);

        // randomized segments
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int i = 0; i < 300; i++)
                cycle($urandom_range(0, 4) == 0,
                      $urandom_range(0, 5) == 0, rnd_target(),
                      $urandom_range(0, 9) == 0, rnd_target(),
                      $urandom_range(0, 199) == 0);
        end

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
